// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a byte stream (word count header, program words, XOR checksum),
// assembles little-endian words, writes them to imem at BASE, BASE+4, ...,
// and releases the CPU from reset only after a load with a good checksum.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start; CPU held
// HDR   | collecting the 4-byte word count N
// DATA  | collecting the 4 bytes of one program word
// WRITE | one-cycle imem write strobe for the assembled word
// CSUM  | collecting the 4-byte checksum, compared against the XOR of all words
// DONE  | load succeeded, CPU released; waits for start
// ERR   | bad header or checksum, CPU held; waits for start
module imem_loader #(
  parameter int          DEPTH = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [6:0]  words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;      // bytes 0..2; byte 3 is taken straight from rx_data
  logic [31:0] acc;
  logic [6:0]  n_words;    // only loaded once N is known to be 1..DEPTH
  logic        accept;
  logic        last_byte;
  logic [31:0] word;
  logic [6:0]  wl_next;

  // Handshake, write strobe and the word completed by the current byte
  always_comb begin
    rx_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    we        = (state == S_WRITE);
    accept    = rx_valid && rx_ready;
    last_byte = accept && (byte_idx == 2'd3);
    word      = {rx_data, asm_q};
    wl_next   = words_loaded + 7'd1;
  end

  // Sequencer, byte assembly, checksum and imem address/data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      asm_q        <= 24'd0;
      acc          <= 32'd0;
      n_words      <= 7'd0;
      wa           <= BASE;
      wd           <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 7'd0;
    end else begin
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: ;
        endcase
      end
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_HDR;
            byte_idx     <= 2'd0;
            asm_q        <= 24'd0;
            acc          <= 32'd0;
            words_loaded <= 7'd0;
            wa           <= BASE;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
          end
        end
        S_HDR: begin
          if (last_byte) begin
            if (word == 32'd0) begin
              state <= S_CSUM;
            end else if (word > 32'(DEPTH)) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              state   <= S_DATA;
              n_words <= word[6:0];
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            state <= S_WRITE;
            wd    <= word;
            acc   <= acc ^ word;
          end
        end
        S_WRITE: begin
          words_loaded <= wl_next;
          // wa only advances when another word follows, so it never points
          // past the last word actually written
          if (wl_next == n_words) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
            wa    <= wa + 32'd4;
          end
        end
        S_CSUM: begin
          if (last_byte) begin
            if (word == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and random loads against a word-list
// reference model (expected writes, final status, checksum by plain XOR).
module tb_imem_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          LIMIT = 60;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int errors = 0;
  int checks = 0;

  logic [31:0] wbuf [DEPTH];
  logic [31:0] cap_a [$];
  logic [31:0] cap_d [$];

  imem_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every imem write, sampled mid-cycle
  always @(negedge clk) begin
    if (we === 1'b1) begin
      cap_a.push_back(wa);
      cap_d.push_back(wd);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and return at the negedge just after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) chk("rx_ready_timeout", 32'(t), 32'(0));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit is_data, input bit gap,
                           input bit start_mid);
    for (int k = 0; k < 4; k++) begin
      if (start_mid && k == 2) start = 1'b1;
      send_byte(w[8*k +: 8]);
      start = 1'b0;
      if (k == 3 && is_data) chk("we_latency", 32'(we), 32'(1));
      if (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rx_ready_after_start", 32'(rx_ready), 32'(1));
  endtask

  // Full load: drive the stream, then compare against the reference model
  task automatic run_load(input string tag, input logic [31:0] n_hdr,
                          input logic [31:0] csum, input bit gap, input bit mid_start);
    logic [31:0] x;
    int          exp_n;
    bit          exp_ok;
    cap_a.delete();
    cap_d.delete();
    pulse_start();
    send_word(n_hdr, 1'b0, gap, 1'b0);
    if (n_hdr <= 32'(DEPTH)) begin
      for (int i = 0; i < int'(n_hdr); i++)
        send_word(wbuf[i], 1'b1, gap, mid_start && i == 0);
      send_word(csum, 1'b0, gap, 1'b0);
    end
    repeat (2) @(negedge clk);

    x = 32'd0;
    exp_n = (n_hdr <= 32'(DEPTH)) ? int'(n_hdr) : 0;
    for (int i = 0; i < exp_n; i++) x = x ^ wbuf[i];
    exp_ok = (n_hdr <= 32'(DEPTH)) && (csum == x);

    chk({tag, ":nwrites"}, 32'(cap_a.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < cap_a.size(); i++) begin
      chk({tag, ":wa"}, cap_a[i], BASE + 32'(4 * i));
      chk({tag, ":wd"}, cap_d[i], wbuf[i]);
    end
    chk({tag, ":done"}, 32'(done), 32'(exp_ok));
    chk({tag, ":error"}, 32'(error), 32'(!exp_ok));
    chk({tag, ":cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
    chk({tag, ":rx_ready"}, 32'(rx_ready), 32'(0));
    chk({tag, ":words_loaded"}, 32'(words_loaded), 32'(exp_n));
  endtask

  initial begin
    logic [31:0] x;
    int          n;

    reset = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst:cpu_hold", 32'(cpu_hold), 32'(1));
    chk("rst:rx_ready", 32'(rx_ready), 32'(0));
    chk("rst:we", 32'(we), 32'(0));
    chk("rst:wa", wa, BASE);
    chk("rst:wd", wd, 32'd0);
    chk("rst:done", 32'(done), 32'(0));
    chk("rst:error", 32'(error), 32'(0));
    chk("rst:words_loaded", 32'(words_loaded), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle:rx_ready", 32'(rx_ready), 32'(0));

    wbuf[0] = 32'hE3A0_0005;
    wbuf[1] = 32'hE3A0_1008;
    run_load("good2", 32'd2, 32'h0000_100D, 1'b0, 1'b0);
    run_load("badcsum", 32'd2, 32'h0000_0000, 1'b0, 1'b0);
    run_load("hdr65", 32'd65, 32'h0000_0000, 1'b0, 1'b0);
    run_load("empty", 32'd0, 32'h0000_0000, 1'b0, 1'b0);
    run_load("gaps_midstart", 32'd2, 32'h0000_100D, 1'b1, 1'b1);

    // Full-depth load
    x = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      wbuf[i] = $urandom;
      x = x ^ wbuf[i];
    end
    run_load("full", 32'(DEPTH), x, 1'b0, 1'b0);

    // Random loads, mostly good checksums, random gaps
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      x = 32'd0;
      for (int i = 0; i < n; i++) begin
        wbuf[i] = $urandom;
        x = x ^ wbuf[i];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ ($urandom | 32'd1);
      run_load("rand", 32'(n), x, 1'(($urandom_range(0, 1))), 1'b0);
    end

    // Reset just after the first write of a two-word load
    wbuf[0] = 32'hE3A0_0005;
    wbuf[1] = 32'hE3A0_1008;
    cap_a.delete();
    cap_d.delete();
    pulse_start();
    send_word(32'd2, 1'b0, 1'b0, 1'b0);
    send_word(wbuf[0], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst:wa", wa, BASE);
    chk("midrst:cpu_hold", 32'(cpu_hold), 32'(1));
    chk("midrst:rx_ready", 32'(rx_ready), 32'(0));
    chk("midrst:words_loaded", 32'(words_loaded), 32'(0));
    reset = 1'b1;
    rx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rx_data = 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("midrst:nwrites", 32'(cap_a.size()), 32'(1));
    chk("midrst:rx_ready_idle", 32'(rx_ready), 32'(0));
    chk("midrst:done", 32'(done), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
